imem_boot_loader: RTL and testbench

//  Loads a program image into instruction memory from a byte stream. Holds the 5-stage core in

---
 rtl/imem_boot_loader_pkg.sv | 31 +++
 rtl/imem_boot_loader_word_assembler.sv | 51 +++++
 rtl/imem_boot_loader.sv | 157 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    // state   | meaning
    // IDLE    | waiting for the first start after reset
    // HDR0    | expecting low byte of the word count
    // HDR1    | expecting high byte of the word count
    // DATA    | receiving instruction bytes, 4 per word
    // CHECK   | expecting the trailing checksum byte
    // DONE    | image loaded and verified, core released
    // ERROR   | header overflow or checksum mismatch, core held
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int         HDR_BYTES      = 2;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

    // States in which the loader consumes host bytes.
    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs little-endian host bytes into 32-bit words; pulses o_word_valid
// the cycle after the last byte of each word is accepted.
module imem_boot_loader_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_last_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_valid;

    // Shift bytes in from the top so the first byte lands in bits [7:0];
    // the completed word is captured separately so it holds between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_clear) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (i_byte_en) begin
                if (r_cnt == LAST_BYTE_IDX) begin
                    r_word  <= {i_byte, r_shift};
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_shift <= {i_byte, r_shift[23:8]};
                    r_cnt   <= r_cnt + 2'd1;
                end
            end
        end
    end

    assign o_last_byte  = (r_cnt == LAST_BYTE_IDX);
    assign o_word_valid = r_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream, writes
// it into instruction memory and releases the core only on a valid image.
//
// state | meaning
// IDLE  | post-reset, waiting for start
// HDR0  | word count low byte
// HDR1  | word count high byte, range check
// DATA  | instruction bytes
// CHECK | checksum byte
// DONE  | verified, core_rst_n released
// ERROR | rejected, core held in reset
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("imem_boot_loader: DATA_WIDTH must be 32");
    end

    // Words that fit between BASE_ADDR and the top of imem.
    localparam int                    CAPACITY = (1 << ADDR_WIDTH) - BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    state_t                r_state;
    state_t                w_next;
    logic                  w_xfer;
    logic                  w_start_acc;
    logic                  w_byte_ready;
    logic                  w_data_byte;
    logic                  w_word_done;
    logic                  w_last_word;
    logic                  w_last_byte;
    logic                  w_word_valid;
    logic [31:0]           w_word;
    logic [15:0]           w_n_hdr;
    logic [7:0]            w_sum_next;
    logic [7:0]            r_n_lo;
    logic [15:0]           r_n;
    logic [7:0]            r_sum;
    logic [ADDR_WIDTH:0]   r_widx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_done;
    logic                  r_error;
    logic                  r_core_rst_n;

    assign w_byte_ready = accepts_bytes(r_state);
    assign w_xfer       = byte_valid & w_byte_ready;
    assign w_start_acc  = start & ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERROR));
    assign w_data_byte  = w_xfer & (r_state == ST_DATA);
    assign w_word_done  = w_data_byte & w_last_byte;
    // Index counter is one bit wider than the address, so this never wraps.
    assign w_last_word  = ((32'(r_widx) + 32'd1) == {16'd0, r_n});
    assign w_n_hdr      = {byte_data, r_n_lo};
    assign w_sum_next   = r_sum + byte_data;

    imem_boot_loader_word_assembler u_word_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_acc),
        .i_byte_en    (w_data_byte),
        .i_byte       (byte_data),
        .o_last_byte  (w_last_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_acc) w_next = ST_HDR0;
            ST_HDR0:  if (w_xfer) w_next = ST_HDR1;
            ST_HDR1: begin
                if (w_xfer) begin
                    if (w_n_hdr == 16'd0)                    w_next = ST_CHECK;
                    else if ({16'd0, w_n_hdr} > 32'(CAPACITY)) w_next = ST_ERROR;
                    else                                     w_next = ST_DATA;
                end
            end
            ST_DATA:  if (w_word_done && w_last_word) w_next = ST_CHECK;
            ST_CHECK: if (w_xfer) w_next = (w_sum_next == 8'd0) ? ST_DONE : ST_ERROR;
            ST_DONE:  if (w_start_acc) w_next = ST_HDR0;
            ST_ERROR: if (w_start_acc) w_next = ST_HDR0;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Header capture, running checksum and word index / write address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n_lo <= '0;
            r_n    <= '0;
            r_sum  <= '0;
            r_widx <= '0;
            r_addr <= BASE;
        end else if (w_start_acc) begin
            r_sum  <= '0;
            r_widx <= '0;
        end else begin
            if (w_xfer) r_sum <= w_sum_next;
            if (w_xfer && r_state == ST_HDR0) r_n_lo <= byte_data;
            if (w_xfer && r_state == ST_HDR1) r_n <= w_n_hdr;
            if (w_word_done) begin
                r_widx <= r_widx + 1'b1;
                r_addr <= BASE + r_widx[ADDR_WIDTH-1:0];
            end
        end
    end

    // Status flags follow the state being entered, so they clear on the start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_done       <= (w_next == ST_DONE);
            r_error      <= (w_next == ST_ERROR);
            r_core_rst_n <= (w_next == ST_DONE);
        end
    end

    assign byte_ready = w_byte_ready;
    assign busy       = w_byte_ready;
    assign imem_we    = w_word_valid;
    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;
    assign core_rst_n = r_core_rst_n;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table of byte streams plus
// hand-written reset/boundary sequences, with a write scoreboard.
module tb_imem_boot_loader;

    localparam int AW   = 10;
    localparam int BASE = 0;
    localparam int CAP  = (1 << AW) - BASE;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          error;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];

    // Stream bytes are stored first-byte-first from the MSB end.
    typedef struct packed {
        logic [95:0] bytes;
        logic [3:0]  len;
        logic        gaps;
        logic [3:0]  start_at;
        logic        exp_done;
        logic        exp_err;
        logic [7:0]  exp_writes;
    } vec_t;

    vec_t vecs[6];

    imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            wr_t e;
            we_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e.addr));
                chk("write_data", imem_wdata, e.data);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            failures++;
            $display("FAIL byte_ready_timeout actual=%0d required=<20", t);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int         n;
        logic [7:0] b;
        logic [31:0] w;
        wr_t        e;
        wr_t        last_e;
        bit         have_w;
        exp_q.delete();
        we_cnt = 0;
        have_w = 0;
        last_e = '0;
        w      = '0;
        pulse_start();
        chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, ".done_clr"}, 32'(done), 32'd0);
        chk({tag, ".error_clr"}, 32'(error), 32'd0);
        chk({tag, ".core_rst_after_start"}, 32'(core_rst_n), 32'd0);
        n = int'({v.bytes[87:80], v.bytes[95:88]});
        for (int i = 0; i < int'(v.len); i++) begin
            b = v.bytes[95 - 8*i -: 8];
            if (v.gaps && i > 0) begin
                if (i == int'(v.start_at)) start = 1'b1;
                @(negedge clk);
                if (start) begin
                    start = 1'b0;
                    chk({tag, ".start_ignored_busy"}, 32'(busy), 32'd1);
                end
            end
            if (i >= 2 && n <= CAP && i < 2 + 4*n) begin
                w = {b, w[31:8]};
                if ((i - 2) % 4 == 3) begin
                    e.addr = AW'(BASE + (i - 2) / 4);
                    e.data = w;
                    exp_q.push_back(e);
                    last_e = e;
                    have_w = 1;
                end
            end
            send_byte(b);
        end
        @(negedge clk);
        chk({tag, ".done"}, 32'(done), 32'(v.exp_done));
        chk({tag, ".error"}, 32'(error), 32'(v.exp_err));
        chk({tag, ".core_rst_n"}, 32'(core_rst_n), 32'(v.exp_done));
        chk({tag, ".byte_ready_end"}, 32'(byte_ready), 32'd0);
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
        chk({tag, ".we_count"}, 32'(we_cnt), 32'(v.exp_writes));
        chk({tag, ".pending_writes"}, 32'(exp_q.size()), 32'd0);
        if (have_w) begin
            chk({tag, ".addr_hold"}, 32'(imem_addr), 32'(last_e.addr));
            chk({tag, ".wdata_hold"}, imem_wdata, last_e.data);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, ".imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".error"}, 32'(error), 32'd0);
        chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(BASE));
        chk({tag, ".imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, ".core_rst_n"}, 32'(core_rst_n), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // two words; checksum 0x27 makes the byte sum 0x100
        vecs[0] = '{bytes: 96'h02_00_13_05_50_00_6f_00_00_00_27_00, len: 4'd11, gaps: 1'b0,
                    start_at: 4'd0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 8'd2};
        // same words, bad checksum
        vecs[1] = '{bytes: 96'h02_00_13_05_50_00_6f_00_00_00_28_00, len: 4'd11, gaps: 1'b0,
                    start_at: 4'd0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 8'd2};
        // empty image
        vecs[2] = '{bytes: 96'h00_00_00_00_00_00_00_00_00_00_00_00, len: 4'd3, gaps: 1'b0,
                    start_at: 4'd0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 8'd0};
        // N = 1025, one past capacity
        vecs[3] = '{bytes: 96'h01_04_00_00_00_00_00_00_00_00_00_00, len: 4'd2, gaps: 1'b0,
                    start_at: 4'd0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 8'd0};
        // two words with gaps and a start pulse inside DATA
        vecs[4] = '{bytes: 96'h02_00_13_05_50_00_6f_00_00_00_27_00, len: 4'd11, gaps: 1'b1,
                    start_at: 4'd5, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 8'd2};
        // one word 0xdeadbeef, sum 0x39 + 0xc7 = 0x100
        vecs[5] = '{bytes: 96'h01_00_ef_be_ad_de_c7_00_00_00_00_00, len: 4'd7, gaps: 1'b0,
                    start_at: 4'd0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 8'd1};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b1;
        @(negedge clk);
        chk("idle.byte_ready", 32'(byte_ready), 32'd0);
        chk("idle.busy", 32'(busy), 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // reset after 5 bytes, then a clean reload
        exp_q.delete();
        we_cnt = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = vecs[0].bytes[95 - 8*i -: 8];
            send_byte(b);
        end
        chk("midload.busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midload_rst");
        repeat (2) @(negedge clk);
        chk("midload_rst.busy_held", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midload.no_write", 32'(we_cnt), 32'd0);
        run_vec(vecs[0], "reload");

        // exactly capacity words is accepted into DATA
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        chk("cap_exact.error", 32'(error), 32'd0);
        chk("cap_exact.busy", 32'(busy), 32'd1);
        chk("cap_exact.byte_ready", 32'(byte_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("cap_exact.abandoned", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
